// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell processes a - b LSB first,
// one bit per clock, and publishes diff/borrow/overflow with a one-cycle done pulse.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             br_next;
    logic             d_bit;
    logic             ovf_bit;
    logic             load;
    logic             last;

    // Datapath: the current operand bits always sit at a_sh[0]/b_sh[0], so on
    // the final SHIFT cycle they are the captured MSBs used for overflow.
    always_comb begin
        load     = start && (state != SHIFT);
        last     = (cnt == LAST);
        d_bit    = a_sh[0] ^ b_sh[0] ^ br;
        br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        ovf_bit  = (a_sh[0] != b_sh[0]) && (d_bit != a_sh[0]);
        acc_next = acc >> 1;
        acc_next[WIDTH-1] = d_bit;
    end

    // NOTE: every output of a combinational block gets a default before the
    // case statement so no path leaves a signal unassigned (no latch).
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? SHIFT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else if (load) begin
            a_sh <= a;
            b_sh <= b;
            acc  <= '0;
            cnt  <= '0;
            br   <= 1'b0;
        end else if (state == SHIFT) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            acc  <= acc_next;
            br   <= br_next;
            cnt  <= cnt + CW'(1);
            // Results are only published as a whole, never mid-operation.
            if (last) begin
                diff     <= acc_next;
                borrow   <= br_next;
                overflow <= ovf_bit;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances
// compared against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start8, start1;
    logic [W-1:0] a8, b8;
    logic [0:0]   a1, b1;
    logic         busy8, done8, borrow8, ovf8;
    logic [W-1:0] diff8;
    logic         busy1, done1, borrow1, ovf1;
    logic [0:0]   diff1;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] held_diff;
    logic         held_borrow, held_ovf;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .overflow(ovf8)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1), .overflow(ovf1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: modular difference, unsigned compare, signed range test.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] d, output logic br, output logic ov);
        longint mask, half, sa, sb, r;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        d    = 32'((longint'(a) - longint'(b)) & mask);
        br   = (a < b);
        sa   = (longint'(a) >= half) ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb   = (longint'(b) >= half) ? longint'(b) - (longint'(1) << w) : longint'(b);
        r    = sa - sb;
        ov   = (r > half - 1) || (r < -half);
    endfunction

    task automatic op8(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input string tag,
                       input bit release_rst);
        logic [31:0] ed;
        logic        eb, eo;
        model(W, 32'(ta), 32'(tb_v), ed, eb, eo);
        @(negedge clk);
        a8 = ta; b8 = tb_v; start8 = 1'b1;
        if (release_rst) rst_n = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = W'($urandom); b8 = W'($urandom);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check({tag, "_busy"}, 32'(busy8), 32'd1);
            check({tag, "_nodone"}, 32'(done8), 32'd0);
            check({tag, "_hold"}, 32'(diff8), 32'(held_diff));
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(done8), 32'd1);
        check({tag, "_idle"}, 32'(busy8), 32'd0);
        check({tag, "_diff"}, 32'(diff8), ed);
        check({tag, "_borrow"}, 32'(borrow8), 32'(eb));
        check({tag, "_ovf"}, 32'(ovf8), 32'(eo));
        held_diff = W'(ed); held_borrow = eb; held_ovf = eo;
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done8), 32'd0);
        check({tag, "_stable"}, 32'(diff8), ed);
    endtask

    initial begin
        logic [31:0] ed, ed2;
        logic        eb, eo, eb2, eo2;
        int          ndone, first_at;
        logic [W-1:0] seen_diff [2];
        logic         seen_borrow [2];
        int           seen_at [2];

        rst_n = 1'b0; start8 = 1'b0; start1 = 1'b0;
        a8 = '0; b8 = '0; a1 = '0; b1 = '0;
        held_diff = '0; held_borrow = 1'b0; held_ovf = 1'b0;
        #1;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_diff", 32'(diff8), 32'd0);
        check("rst_borrow", 32'(borrow8), 32'd0);
        check("rst_ovf", 32'(ovf8), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op8(8'h05, 8'h03, "d05_03", 1'b0);
        op8(8'h03, 8'h05, "d03_05", 1'b0);
        op8(8'h80, 8'h01, "d80_01", 1'b0);
        op8(8'h7F, 8'hFF, "d7f_ff", 1'b0);
        op8(8'h00, 8'hFF, "d00_ff", 1'b0);
        op8(8'h00, 8'h00, "d00_00", 1'b0);
        for (int r = 0; r < 16; r++) op8(W'($urandom), W'($urandom), "rand", 1'b0);

        // start during SHIFT must be ignored
        model(W, 32'h3C, 32'h5A, ed, eb, eo);
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h5A; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        ndone = 0; first_at = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 3) begin a8 = 8'hC3; b8 = 8'h11; start8 = 1'b1; end
            if (n == 4) start8 = 1'b0;
            if (done8 === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    first_at = n;
                    check("ign_diff", 32'(diff8), ed);
                    check("ign_borrow", 32'(borrow8), 32'(eb));
                    check("ign_ovf", 32'(ovf8), 32'(eo));
                end
            end
        end
        check("ign_ndone", 32'(ndone), 32'd1);
        check("ign_latency", 32'(first_at), 32'(W + 1));
        held_diff = W'(ed);

        // start held high through DONE: back-to-back with no idle cycle
        model(W, 32'h10, 32'h20, ed, eb, eo);
        model(W, 32'hFF, 32'hFF, ed2, eb2, eo2);
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
        @(posedge clk);
        #1 a8 = 8'hFF; b8 = 8'hFF;
        ndone = 0;
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            if (n == W + 2) begin
                check("b2b_nogap_busy", 32'(busy8), 32'd1);
                start8 = 1'b0;
            end
            if (done8 === 1'b1) begin
                if (ndone < 2) begin
                    seen_at[ndone] = n; seen_diff[ndone] = diff8; seen_borrow[ndone] = borrow8;
                end
                ndone++;
            end
        end
        check("b2b_ndone", 32'(ndone), 32'd2);
        check("b2b_at0", 32'(seen_at[0]), 32'(W + 1));
        check("b2b_diff0", 32'(seen_diff[0]), ed);
        check("b2b_borrow0", 32'(seen_borrow[0]), 32'(eb));
        check("b2b_at1", 32'(seen_at[1]), 32'(2 * W + 2));
        check("b2b_diff1", 32'(seen_diff[1]), ed2);
        check("b2b_borrow1", 32'(seen_borrow[1]), 32'(eb2));
        held_diff = W'(ed2);

        // reset in the middle of SHIFT aborts the operation
        op8(8'h03, 8'h05, "pre_rst", 1'b0);
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        check("abort_diff", 32'(diff8), 32'd0);
        check("abort_borrow", 32'(borrow8), 32'd0);
        check("abort_ovf", 32'(ovf8), 32'd0);
        held_diff = '0;
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 2 * W; n++) begin
            @(negedge clk);
            if (done8 === 1'b1 || busy8 === 1'b1) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        rst_n = 1'b0;
        // start accepted on the first edge after reset release
        op8(8'h80, 8'h01, "post_rst", 1'b1);

        // WIDTH=1: half-subtractor with 1-cycle latency
        for (int p = 0; p < 4; p++) begin
            logic [1:0] pv;
            pv = 2'(p);
            model(1, 32'(pv[1]), 32'(pv[0]), ed, eb, eo);
            @(negedge clk);
            a1 = pv[1]; b1 = pv[0]; start1 = 1'b1;
            @(posedge clk);
            #1 start1 = 1'b0; a1 = ~pv[1]; b1 = ~pv[0];
            @(negedge clk);
            check("w1_busy", 32'(busy1), 32'd1);
            check("w1_nodone", 32'(done1), 32'd0);
            @(negedge clk);
            check("w1_done", 32'(done1), 32'd1);
            check("w1_diff", 32'(diff1), ed);
            check("w1_borrow", 32'(borrow1), 32'(eb));
            check("w1_ovf", 32'(ovf1), 32'(eo));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand/result width in bits; legal range 1..32.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin a subtraction; sampled on clk rising edge.
REQ-005 SHALL have port a, input, WIDTH, minuend; captured when start is accepted.
REQ-006 SHALL have port b, input, WIDTH, subtrahend; captured when start is accepted.
REQ-007 SHALL have port busy, output, 1, high while a subtraction is in progress.
REQ-008 SHALL have port done, output, 1, single-cycle pulse marking valid results.
REQ-009 SHALL have port diff, output, WIDTH, a - b modulo 2^WIDTH.
REQ-010 SHALL have port borrow, output, 1, final borrow out; 1 iff unsigned a < b.
REQ-011 SHALL have port overflow, output, 1, two's-complement signed overflow of a - b.

Function
REQ-012 SHALL implement an FSM with states IDLE, SHIFT, DONE.
REQ-013 SHALL accept start only when busy=0 (state IDLE or DONE); on acceptance, capture a and b, clear the internal borrow flop to 0, clear the bit counter to 0, and enter SHIFT.
REQ-014 SHALL ignore start while in SHIFT; a and b changes during SHIFT SHALL NOT affect the result.
REQ-015 SHALL, in SHIFT, process one bit per cycle, LSB first, using a full-subtractor cell: d_i = a_i XOR b_i XOR br; br_next = (~a_i & b_i) | (~(a_i XOR b_i) & br).
REQ-016 SHALL increment the bit counter each SHIFT cycle; after bit WIDTH-1 is processed, it SHALL transition to DONE.
REQ-017 SHALL set busy=1 exactly in SHIFT (WIDTH cycles); busy=0 in IDLE and DONE.
REQ-018 SHALL, if start is accepted at edge k, update diff, borrow, and overflow and assert done at edge k+WIDTH; done SHALL be high for exactly one cycle.
REQ-019 SHALL go from DONE to IDLE on the next edge, or to SHIFT if start=1 in DONE (back-to-back operation with no gap).
REQ-020 SHALL hold diff, borrow, and overflow stable from their update until the next result update; they SHALL NOT show partial results during SHIFT.
REQ-021 SHALL compute overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using captured operands.
REQ-022 SHALL, for WIDTH=1, produce diff = a XOR b and borrow = ~a & b (half-subtractor truth table) with 1-cycle latency.
REQ-023 SHALL use a bit counter of width max(1, clog2(WIDTH)) bits; the counter SHALL NOT wrap before DONE.

Reset
REQ-024 SHALL, while rst_n=0, force state=IDLE, busy=0, done=0, diff=0, borrow=0, overflow=0, internal borrow=0, counter=0, independent of clk.
REQ-025 SHALL abort any in-progress operation on reset assertion; no done pulse SHALL follow for the aborted operation.
REQ-026 SHALL accept start on the first rising edge after rst_n deasserts.

Verification (WIDTH=8 unless stated)
REQ-027 SHALL verify a=0x05, b=0x03, start pulse -> after 8 cycles done=1 for 1 cycle, diff=0x02, borrow=0, overflow=0.
REQ-028 SHALL verify a=0x03, b=0x05 -> diff=0xFE, borrow=1, overflow=0; and a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1.
REQ-029 SHALL verify start pulsed at cycle 3 of SHIFT with new operands -> ignored; result matches the first operands and only one done pulse occurs.
REQ-030 SHALL verify start held high through DONE with a=0xFF, b=0xFF -> second operation begins with no idle cycle; diff=0x00, borrow=0.
REQ-031 SHALL verify rst_n pulsed low at cycle 4 of SHIFT -> outputs=0 immediately; no done pulse follows; the next start works normally.
REQ-032 SHALL verify, for WIDTH=1, all four (a,b) pairs -> (diff,borrow) = 00:(0,0), 01:(1,1), 10:(1,0), 11:(0,0).
